vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
Sequences the physical back end of the vending machine once the coin FSM has decided to vend or refund. It drives the bottle motor and watches the drop sensor with a timeout, then pays out change one 5rs coin at a time over a handshake with the coin hopper. It sits between the coin-accept FSM (requester) and the motor/hopper drivers. It arbitrates vend and refund requests that arrive in the same cycle.

Parameters:
MOTOR_CYCLES, 8, number of cycles motor_on is held high per vend (>=1)
DROP_TIMEOUT, 64, max cycles to wait for drop_sense after the motor phase
HOP_TIMEOUT, 32, max cycles to wait for coin_done after each coin_eject

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
vend_req  input  1  request to dispense one bottle plus vend_chg coins
vend_chg  input  2  number of 5rs coins to return with the vend (0-3)
refund_req  input  1  request to return refund_chg coins, no bottle
refund_chg  input  2  number of 5rs coins to refund (0-3)
req_ack  output  1  one-cycle pulse: request accepted
busy  output  1  high whenever state != IDLE
motor_on  output  1  bottle motor drive
drop_sense  input  1  bottle-drop sensor, already synchronised, level
coin_eject  output  1  one-cycle pulse: hopper ejects one 5rs coin
coin_done  input  1  hopper pulse: coin ejected
done  output  1  one-cycle pulse: transaction complete
fault  output  1  sticky fault flag
fault_clr  input  1  clears fault, returns to IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; coin counter and timer 0. Reset mid-operation aborts immediately: motor_on and coin_eject drop asynchronously.
- All outputs registered; they change on the clk edge after the causing input is sampled.
- States: IDLE, MOTOR, WAIT_DROP, CHANGE, EJECT_WAIT, DONE, FAULT.
- IDLE:
  - vend_req=1: latch vend_chg, pulse req_ack, go MOTOR.
  - else refund_req=1: latch refund_chg, pulse req_ack, go CHANGE (or DONE if refund_chg=0).
  - Simultaneous vend_req and refund_req: vend wins. The refund is not acked and must be re-held by the requester.
  - Requests in any non-IDLE state are ignored; no ack.
- MOTOR: motor_on=1 for exactly MOTOR_CYCLES cycles, then go WAIT_DROP. A drop_sense seen during MOTOR is latched as drop_seen.
- WAIT_DROP:
  - drop_seen or drop_sense=1: go CHANGE if coins>0, else DONE.
  - Timer counts from 0. At DROP_TIMEOUT cycles with no drop: go FAULT. No change is paid.
- CHANGE: coin_eject=1 for one cycle, go EJECT_WAIT, reset timer.
- EJECT_WAIT:
  - coin_done=1: decrement coins. Go CHANGE if coins now >0, else DONE.
  - Timeout at HOP_TIMEOUT cycles: go FAULT.
  - coin_done outside EJECT_WAIT is ignored.
- DONE: done=1 for one cycle, go IDLE. busy deasserts in the same cycle as the return to IDLE.
- FAULT:
  - fault=1, motor_on=0, coin_eject=0. Remains until fault_clr=1, then go IDLE with fault=0 on the next edge.
  - fault_clr in any other state has no effect.
- Counter widths: coin counter 2 bits; timer sized to clog2 of max(DROP_TIMEOUT, HOP_TIMEOUT)+1. No wrap: the timer saturates at the timeout compare.
- Back-to-back transactions: a new request can be acked in the cycle after DONE, when the state is IDLE.

Test Plan:
- Reset, then vend_req=1 with vend_chg=0; drop_sense pulses 3 cycles after the motor phase -> req_ack 1 cycle; motor_on high exactly 8 cycles; done pulses once; coin_eject never asserts.
- vend_req with vend_chg=2; hopper answers coin_done 2 cycles after each eject -> exactly 2 coin_eject pulses, done after the second coin_done, busy low the next cycle.
- vend_req and refund_req high together (refund_chg=3) -> vend path taken (motor_on rises). After done, refund_req still held -> acked, 3 coin_eject pulses, no motor_on.
- vend_req with no drop_sense -> fault=1 after 8+64 cycles, no coin_eject. A vend_req during FAULT gives no ack. fault_clr=1 -> IDLE, fault=0.
- refund_chg=1 with no coin_done -> fault after 32 cycles in EJECT_WAIT.
- rst_n low during MOTOR (cycle 4) -> motor_on=0 immediately, busy=0. After release, a new vend_req is accepted normally.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl
//
// Back-end sequencer of the vending machine. Once the coin FSM decides to
// vend or refund, this block runs the bottle motor, waits for the drop
// sensor (with timeout), then pays change one 5rs coin at a time over a
// pulse handshake with the coin hopper. A vend and a refund arriving in the
// same cycle are arbitrated in favour of the vend.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   vend_req, vend_chg    vend one bottle plus vend_chg coins of change
//   refund_req, refund_chg  refund refund_chg coins, no bottle
//   req_ack               1-cycle pulse: request accepted
//   busy                  high whenever the controller is not idle
//   motor_on              bottle motor drive
//   drop_sense            synchronised bottle-drop sensor (level)
//   coin_eject            1-cycle pulse: hopper ejects one coin
//   coin_done             hopper pulse: coin has been ejected
//   done                  1-cycle pulse: transaction complete
//   fault                 sticky fault flag (drop or hopper timeout)
//   fault_clr             clears fault and returns to idle
// ---------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 64,
    parameter int HOP_TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vend_req,
    input  logic [1:0] vend_chg,
    input  logic       refund_req,
    input  logic [1:0] refund_chg,
    output logic       req_ack,
    output logic       busy,
    output logic       motor_on,
    input  logic       drop_sense,
    output logic       coin_eject,
    input  logic       coin_done,
    output logic       done,
    output logic       fault,
    input  logic       fault_clr
);

    // The timer also paces the motor phase, so it must hold MOTOR_CYCLES-1.
    localparam int TMAX_DH = (DROP_TIMEOUT > HOP_TIMEOUT) ? DROP_TIMEOUT : HOP_TIMEOUT;
    localparam int TMAX    = (TMAX_DH > MOTOR_CYCLES) ? TMAX_DH : MOTOR_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0] MOTOR_LAST = TW'(MOTOR_CYCLES - 1);
    localparam logic [TW-1:0] DROP_LAST  = TW'(DROP_TIMEOUT - 1);
    localparam logic [TW-1:0] HOP_LAST   = TW'(HOP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        WAIT_DROP,
        CHANGE,
        EJECT_WAIT,
        DONE,
        FAULT
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    coins, coins_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          drop_seen, drop_seen_nx;
    logic          ack_nx;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        coins_nx     = coins;
        timer_nx     = timer;
        drop_seen_nx = drop_seen;
        ack_nx       = 1'b0;

        case (state)
            IDLE: begin
                timer_nx     = '0;
                drop_seen_nx = 1'b0;
                // Vend has priority; a simultaneous refund stays un-acked.
                if (vend_req) begin
                    coins_nx = vend_chg;
                    ack_nx   = 1'b1;
                    state_nx = MOTOR;
                end else if (refund_req) begin
                    coins_nx = refund_chg;
                    ack_nx   = 1'b1;
                    state_nx = (refund_chg != 2'd0) ? CHANGE : DONE;
                end
            end

            MOTOR: begin
                // A bottle can fall while the motor is still turning.
                drop_seen_nx = drop_seen | drop_sense;
                if (timer == MOTOR_LAST) begin
                    timer_nx = '0;
                    state_nx = WAIT_DROP;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            WAIT_DROP: begin
                if (drop_seen || drop_sense) begin
                    timer_nx = '0;
                    state_nx = (coins != 2'd0) ? CHANGE : DONE;
                end else if (timer == DROP_LAST) begin
                    state_nx = FAULT;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            CHANGE: begin
                timer_nx = '0;
                state_nx = EJECT_WAIT;
            end

            EJECT_WAIT: begin
                // A coin_done arriving on the last timeout cycle still counts.
                if (coin_done) begin
                    coins_nx = coins - 1'b1;
                    timer_nx = '0;
                    state_nx = (coins != 2'd1) ? CHANGE : DONE;
                end else if (timer == HOP_LAST) begin
                    state_nx = FAULT;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            DONE: state_nx = IDLE;

            FAULT: begin
                timer_nx = '0;
                if (fault_clr) state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state register and clear asynchronously together with it.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            coins      <= '0;
            timer      <= '0;
            drop_seen  <= 1'b0;
            req_ack    <= 1'b0;
            busy       <= 1'b0;
            motor_on   <= 1'b0;
            coin_eject <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nx;
            coins      <= coins_nx;
            timer      <= timer_nx;
            drop_seen  <= drop_seen_nx;
            req_ack    <= ack_nx;
            busy       <= (state_nx != IDLE);
            motor_on   <= (state_nx == MOTOR);
            coin_eject <= (state_nx == CHANGE);
            done       <= (state_nx == DONE);
            fault      <= (state_nx == FAULT);
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_dispense_ctrl
//
// Self-checking bench for vend_dispense_ctrl. Each scenario task pushes the
// expected transaction outcome (motor cycles, coin ejects, done or fault)
// onto a scoreboard queue when it issues a request; a monitor pops and
// compares when the DUT ends a transaction with done or a fault edge.
// Scenario tasks additionally check latencies and handshakes inline.
// ---------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

    localparam int MOTOR_CYCLES = 8;
    localparam int DROP_TIMEOUT = 64;
    localparam int HOP_TIMEOUT  = 32;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       vend_req   = 1'b0;
    logic [1:0] vend_chg   = 2'd0;
    logic       refund_req = 1'b0;
    logic [1:0] refund_chg = 2'd0;
    logic       drop_sense = 1'b0;
    logic       coin_done  = 1'b0;
    logic       fault_clr  = 1'b0;
    logic       req_ack, busy, motor_on, coin_eject, done, fault;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int motor;
        int ejects;
        bit is_fault;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    bit   hop_en  = 1'b0;
    int   hop_dly = 0;
    int   m_cnt   = 0;
    int   e_cnt   = 0;
    int   a_cnt   = 0;
    logic fault_q = 1'b0;

    vend_dispense_ctrl #(
        .MOTOR_CYCLES(MOTOR_CYCLES),
        .DROP_TIMEOUT(DROP_TIMEOUT),
        .HOP_TIMEOUT (HOP_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vend_req  (vend_req),
        .vend_chg  (vend_chg),
        .refund_req(refund_req),
        .refund_chg(refund_chg),
        .req_ack   (req_ack),
        .busy      (busy),
        .motor_on  (motor_on),
        .drop_sense(drop_sense),
        .coin_eject(coin_eject),
        .coin_done (coin_done),
        .done      (done),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    always #5 clk = ~clk;

    // Hopper model: answers each coin_eject with a coin_done two cycles later.
    always @(negedge clk) begin
        coin_done = 1'b0;
        if (!hop_en) begin
            hop_dly = 0;
        end else begin
            if (hop_dly > 0) begin
                hop_dly--;
                if (hop_dly == 0) coin_done = 1'b1;
            end
            if (coin_eject) hop_dly = 2;
        end
    end

    // Scoreboard monitor: accumulate per-transaction activity, compare at end.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; e_cnt = 0; a_cnt = 0; fault_q = 1'b0;
        end else begin
            if (motor_on)   m_cnt++;
            if (coin_eject) e_cnt++;
            if (req_ack)    a_cnt++;
            if (done || (fault && !fault_q)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: transaction ended with nothing expected");
                end else begin
                    mon_e = exp_q.pop_front();
                    n_total++;
                    if (m_cnt !== mon_e.motor)
                        $display("FAIL sb_motor: got %0d motor cycles, want %0d", m_cnt, mon_e.motor);
                    else n_pass++;
                    n_total++;
                    if (e_cnt !== mon_e.ejects)
                        $display("FAIL sb_ejects: got %0d coin_eject pulses, want %0d", e_cnt, mon_e.ejects);
                    else n_pass++;
                    n_total++;
                    if (fault !== mon_e.is_fault)
                        $display("FAIL sb_outcome: got fault=%b, want fault=%b", fault, mon_e.is_fault);
                    else n_pass++;
                    n_total++;
                    if (a_cnt !== 1)
                        $display("FAIL sb_acks: got %0d req_ack pulses, want 1", a_cnt);
                    else n_pass++;
                end
                m_cnt = 0; e_cnt = 0; a_cnt = 0;
            end
            fault_q = fault;
        end
    end

    function automatic void expect_txn(input int motor, input int ejects, input bit is_fault);
        exp_t e;
        e.motor    = motor;
        e.ejects   = ejects;
        e.is_fault = is_fault;
        exp_q.push_back(e);
    endfunction

    task automatic wait_end(input int budget, input string name);
        int cyc;
        cyc = 0;
        while (!(done || fault) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (done || fault) n_pass++;
        else $display("FAIL %s: no done/fault within %0d cycles", name, cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({req_ack, busy, motor_on, coin_eject, done, fault} !== 6'b0)
            $display("FAIL reset_outputs: got %b, want 000000",
                     {req_ack, busy, motor_on, coin_eject, done, fault});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({req_ack, busy, motor_on, coin_eject, done, fault} !== 6'b0)
            $display("FAIL reset_idle: got %b, want 000000",
                     {req_ack, busy, motor_on, coin_eject, done, fault});
        else n_pass++;
    endtask

    task automatic test_vend_no_change();
        int hi, acks;
        vend_req = 1'b1; vend_chg = 2'd0;
        expect_txn(MOTOR_CYCLES, 0, 1'b0);
        @(negedge clk);
        vend_req = 1'b0;
        hi = 0; acks = 0;
        for (int i = 0; i < MOTOR_CYCLES; i++) begin
            if (motor_on) hi++;
            if (req_ack)  acks++;
            @(negedge clk);
        end
        n_total++;
        if (hi !== MOTOR_CYCLES) $display("FAIL vend0_motor_len: got %0d, want %0d", hi, MOTOR_CYCLES);
        else n_pass++;
        n_total++;
        if (acks !== 1) $display("FAIL vend0_ack_pulse: got %0d acks, want 1", acks);
        else n_pass++;
        n_total++;
        if (motor_on !== 1'b0) $display("FAIL vend0_motor_off: got %b, want 0", motor_on);
        else n_pass++;
        repeat (2) @(negedge clk);
        drop_sense = 1'b1;
        @(negedge clk);
        drop_sense = 1'b0;
        wait_end(20, "vend0_end");
        n_total++;
        if (done !== 1'b1) $display("FAIL vend0_done: got %b, want 1", done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done, busy} !== 2'b00) $display("FAIL vend0_idle: got done,busy=%b, want 00", {done, busy});
        else n_pass++;
    endtask

    task automatic test_vend_change();
        hop_en = 1'b1;
        vend_req = 1'b1; vend_chg = 2'd2;
        expect_txn(MOTOR_CYCLES, 2, 1'b0);
        @(negedge clk);
        vend_req = 1'b0;
        n_total++;
        if (req_ack !== 1'b1) $display("FAIL chg2_ack: got %b, want 1", req_ack);
        else n_pass++;
        // Drop arrives while the motor still runs and must be remembered.
        repeat (2) @(negedge clk);
        drop_sense = 1'b1;
        @(negedge clk);
        drop_sense = 1'b0;
        wait_end(40, "chg2_end");
        n_total++;
        if (done !== 1'b1) $display("FAIL chg2_done: got %b, want 1", done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL chg2_busy_after: got %b, want 0", busy);
        else n_pass++;
        hop_en = 1'b0;
    endtask

    task automatic test_arbitration();
        hop_en = 1'b1;
        drop_sense = 1'b1;
        vend_req = 1'b1; vend_chg = 2'd0;
        refund_req = 1'b1; refund_chg = 2'd3;
        expect_txn(MOTOR_CYCLES, 0, 1'b0);
        expect_txn(0, 3, 1'b0);
        @(negedge clk);
        vend_req = 1'b0;
        n_total++;
        if ({req_ack, motor_on} !== 2'b11) $display("FAIL arb_vend_wins: got ack,motor=%b, want 11", {req_ack, motor_on});
        else n_pass++;
        wait_end(30, "arb_vend_end");
        @(negedge clk);
        n_total++;
        if ({req_ack, busy} !== 2'b00) $display("FAIL arb_idle_gap: got ack,busy=%b, want 00", {req_ack, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({req_ack, coin_eject, motor_on} !== 3'b110)
            $display("FAIL arb_refund_ack: got ack,eject,motor=%b, want 110", {req_ack, coin_eject, motor_on});
        else n_pass++;
        refund_req = 1'b0;
        drop_sense = 1'b0;
        wait_end(40, "arb_refund_end");
        @(negedge clk);
        hop_en = 1'b0;
    endtask

    task automatic test_drop_timeout();
        int cyc, acks;
        vend_req = 1'b1; vend_chg = 2'd1;
        expect_txn(MOTOR_CYCLES, 0, 1'b1);
        @(negedge clk);
        vend_req = 1'b0;
        cyc = 0;
        while (!fault && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (cyc !== MOTOR_CYCLES + DROP_TIMEOUT)
            $display("FAIL drop_to_latency: got %0d cycles, want %0d", cyc, MOTOR_CYCLES + DROP_TIMEOUT);
        else n_pass++;
        vend_req = 1'b1;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_ack) acks++;
        end
        vend_req = 1'b0;
        n_total++;
        if (acks !== 0) $display("FAIL fault_no_ack: got %0d acks, want 0", acks);
        else n_pass++;
        n_total++;
        if (fault !== 1'b1) $display("FAIL fault_sticky: got %b, want 1", fault);
        else n_pass++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_total++;
        if ({fault, busy} !== 2'b00) $display("FAIL drop_fault_clr: got fault,busy=%b, want 00", {fault, busy});
        else n_pass++;
    endtask

    task automatic test_hop_timeout();
        int cyc;
        hop_en = 1'b0;
        refund_req = 1'b1; refund_chg = 2'd1;
        expect_txn(0, 1, 1'b1);
        @(negedge clk);
        refund_req = 1'b0;
        n_total++;
        if (coin_eject !== 1'b1) $display("FAIL hop_eject: got %b, want 1", coin_eject);
        else n_pass++;
        cyc = 0;
        while (!fault && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (cyc !== HOP_TIMEOUT + 1)
            $display("FAIL hop_to_latency: got %0d cycles, want %0d", cyc, HOP_TIMEOUT + 1);
        else n_pass++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_total++;
        if ({fault, busy} !== 2'b00) $display("FAIL hop_fault_clr: got fault,busy=%b, want 00", {fault, busy});
        else n_pass++;
    endtask

    task automatic test_reset_mid_motor();
        vend_req = 1'b1; vend_chg = 2'd0;
        @(negedge clk);
        vend_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({motor_on, busy} !== 2'b00) $display("FAIL rst_async: got motor,busy=%b, want 00", {motor_on, busy});
        else n_pass++;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        drop_sense = 1'b1;
        vend_req = 1'b1;
        expect_txn(MOTOR_CYCLES, 0, 1'b0);
        @(negedge clk);
        vend_req = 1'b0;
        n_total++;
        if ({req_ack, motor_on} !== 2'b11) $display("FAIL rst_reaccept: got ack,motor=%b, want 11", {req_ack, motor_on});
        else n_pass++;
        wait_end(30, "rst_vend_end");
        drop_sense = 1'b0;
        n_total++;
        if (done !== 1'b1) $display("FAIL rst_vend_done: got %b, want 1", done);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vend_no_change();
        test_vend_change();
        test_arbitration();
        test_drop_timeout();
        test_hop_timeout();
        test_reset_mid_motor();
        repeat (2) @(negedge clk);
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL sb_drained: %0d expected transactions never completed", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
